// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM command encodings, BL/CL mode constants and bus widths
package sdram_pkg;
  localparam int ADDR_W = 13;
  localparam int BA_W = 2;
  typedef enum logic [3:0] {
    CMD_MRS   = 4'b0000,
    CMD_REF   = 4'b0001,
    CMD_PRE   = 4'b0010,
    CMD_ACT   = 4'b0011,
    CMD_WRITE = 4'b0100,
    CMD_READ  = 4'b0101,
    CMD_BST   = 4'b0110,
    CMD_NOP   = 4'b0111
  } cmd_e;
  localparam logic [2:0] BL_1 = 3'd0;
  localparam logic [2:0] BL_2 = 3'd1;
  localparam logic [2:0] BL_4 = 3'd2;
  localparam logic [2:0] BL_8 = 3'd3;
  localparam logic [2:0] CL_2 = 3'd2;
  localparam logic [2:0] CL_3 = 3'd3;
  function automatic logic [2:0] bl_mask(input logic [1:0] code);
    return 3'((4'd1 << code) - 4'd1);
  endfunction
endpackage

// File: rtl/sdram_bank_state.sv
// sdram_bank_state: one bank's open flag, open row and tRCD/tRP countdown timers (act_i/pre_i in; open_o, row_o, trcd_ok_o, trp_ok_o out)
module sdram_bank_state #(
  parameter int ROW_BITS = 4,
  parameter int TRCD = 2,
  parameter int TRP = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                act_i,
  input  logic                pre_i,
  input  logic [ROW_BITS-1:0] row_i,
  output logic                open_o,
  output logic [ROW_BITS-1:0] row_o,
  output logic                trcd_ok_o,
  output logic                trp_ok_o
);
  localparam int TW = 4;
  logic          open_q;
  logic [ROW_BITS-1:0] row_q;
  logic [TW-1:0] trcd_q, trp_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      open_q <= 1'b0;
      row_q  <= '0;
      trcd_q <= '0;
      trp_q  <= '0;
    end else begin
      open_q <= act_i || (open_q && !pre_i);
      row_q  <= act_i ? row_i : row_q;
      trcd_q <= act_i ? TW'(TRCD - 1) : trcd_q - TW'(trcd_q != '0);
      trp_q  <= pre_i ? TW'(TRP - 1) : trp_q - TW'(trp_q != '0);
    end
  end
  assign open_o    = open_q;
  assign row_o     = row_q;
  assign trcd_ok_o = trcd_q == '0;
  assign trp_ok_o  = trp_q == '0;
endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: SDRAM far-end model; decodes DRAM_* commands into a banked memory, returns CL-delayed read bursts on dq_out/dq_oe, latches protocol violations on err
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 6,
  parameter int TRCD = 2,
  parameter int TRP = 2
) (
  input  logic              CLOCK_100,
  input  logic              rst,
  input  logic              DRAM_CKE,
  input  logic              DRAM_CS_N,
  input  logic              DRAM_RAS_N,
  input  logic              DRAM_CAS_N,
  input  logic              DRAM_WE_N,
  input  logic [BA_W-1:0]   DRAM_BA,
  input  logic [ADDR_W-1:0] DRAM_ADDR,
  input  logic [1:0]        DRAM_DQM,
  input  logic [15:0]       dq_in,
  output logic [15:0]       dq_out,
  output logic              dq_oe,
  output logic              err
);
  localparam int AW = BA_W + ROW_BITS + COL_BITS;
  cmd_e cmd;
  logic is_act, is_pre, is_rd, is_wr, is_ref, is_mrs, is_bst;
  logic act_bad, rw_bad, mrs_bad, viol, go, stop;
  logic [3:0] bank_open, trcd_ok, trp_ok, act_v, pre_v;
  logic [ROW_BITS-1:0] bank_row [4];
  logic bst_q, bwr_q, bap_q, cl3_q, err_q;
  logic [BA_W-1:0] bbank_q, cur_bank;
  logic [1:0] bl_q;
  logic [ROW_BITS-1:0] brow_q, cur_row;
  logic [COL_BITS-1:0] bcol_q, cur_base, cur_col;
  logic [2:0] bk_q, bmask_q, cur_k, cur_mask;
  logic cur_act, cur_wr, cur_ap, cur_last;
  logic [AW-1:0] idx;
  logic [15:0] mem [2**AW];
  logic [16:0] pipe_q [3];
  logic unused_addr;
  for (genvar b = 0; b < 4; b++) begin : g_bank
    sdram_bank_state #(.ROW_BITS(ROW_BITS), .TRCD(TRCD), .TRP(TRP)) u_bank (
      .clk_i    (CLOCK_100),
      .rst_i    (rst),
      .act_i    (act_v[b]),
      .pre_i    (pre_v[b]),
      .row_i    (DRAM_ADDR[ROW_BITS-1:0]),
      .open_o   (bank_open[b]),
      .row_o    (bank_row[b]),
      .trcd_ok_o(trcd_ok[b]),
      .trp_ok_o (trp_ok[b])
    );
  end
  always_comb begin
    cmd      = (!DRAM_CKE || DRAM_CS_N) ? CMD_NOP : cmd_e'({DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N});
    is_act   = cmd == CMD_ACT;
    is_pre   = cmd == CMD_PRE;
    is_rd    = cmd == CMD_READ;
    is_wr    = cmd == CMD_WRITE;
    is_ref   = cmd == CMD_REF;
    is_mrs   = cmd == CMD_MRS;
    is_bst   = cmd == CMD_BST;
    act_bad  = bank_open[DRAM_BA] || !trp_ok[DRAM_BA];
    rw_bad   = !bank_open[DRAM_BA] || !trcd_ok[DRAM_BA];
    mrs_bad  = |bank_open || !(DRAM_ADDR[6:4] == CL_2 || DRAM_ADDR[6:4] == CL_3) || DRAM_ADDR[2:0] > BL_8;
    viol     = (is_act && act_bad) || ((is_rd || is_wr) && rw_bad) || (is_ref && |bank_open) || (is_mrs && mrs_bad);
    go       = (is_rd || is_wr) && !rw_bad;
    stop     = go || is_bst;
    cur_act  = go || (bst_q && !stop);
    cur_wr   = go ? is_wr : bwr_q;
    cur_ap   = go ? DRAM_ADDR[10] : bap_q;
    cur_bank = go ? DRAM_BA : bbank_q;
    cur_row  = go ? bank_row[DRAM_BA] : brow_q;
    cur_base = go ? DRAM_ADDR[COL_BITS-1:0] : bcol_q;
    cur_mask = go ? bl_mask(bl_q) : bmask_q;
    cur_k    = go ? 3'd0 : bk_q;
    cur_col  = {cur_base[COL_BITS-1:3], (cur_base[2:0] & ~cur_mask) | ((cur_base[2:0] + cur_k) & cur_mask)};
    cur_last = cur_k == cur_mask;
    idx      = {cur_bank, cur_row, cur_col};
    act_v    = (is_act && !act_bad) ? 4'b0001 << DRAM_BA : 4'b0000;
    pre_v    = (is_pre ? (DRAM_ADDR[10] ? 4'b1111 : 4'b0001 << DRAM_BA) : 4'b0000)
             | ((cur_act && cur_last && cur_ap) ? 4'b0001 << cur_bank : 4'b0000);
  end
  always_ff @(posedge CLOCK_100) begin
    if (rst) begin
      bst_q     <= 1'b0;
      err_q     <= 1'b0;
      cl3_q     <= 1'b0;
      bl_q      <= BL_1[1:0];
      pipe_q[0] <= '0;
      pipe_q[1] <= '0;
      pipe_q[2] <= '0;
    end else begin
      bst_q     <= cur_act && !cur_last;
      bwr_q     <= cur_wr;
      bap_q     <= cur_ap;
      bbank_q   <= cur_bank;
      brow_q    <= cur_row;
      bcol_q    <= cur_base;
      bmask_q   <= cur_mask;
      bk_q      <= cur_k + 3'd1;
      pipe_q[0] <= (cur_act && !cur_wr) ? {1'b1, mem[idx]} : '0;
      pipe_q[1] <= (go && is_wr) ? '0 : pipe_q[0];
      pipe_q[2] <= (go && is_wr) ? '0 : pipe_q[1];
      err_q     <= err_q || viol;
      if (is_mrs && !mrs_bad) begin
        cl3_q <= DRAM_ADDR[4];
        bl_q  <= DRAM_ADDR[1:0];
      end
    end
  end
  always_ff @(posedge CLOCK_100) begin
    if (!rst && cur_act && cur_wr) begin
      if (!DRAM_DQM[0]) mem[idx][7:0] <= dq_in[7:0];
      if (!DRAM_DQM[1]) mem[idx][15:8] <= dq_in[15:8];
    end
  end
  assign {dq_oe, dq_out} = cl3_q ? pipe_q[2] : pipe_q[1];
  assign err = err_q;
  assign unused_addr = ^DRAM_ADDR;
endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed scoreboard bench for sdram_responder
module tb_sdram_responder;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] BST = 4'b0110, PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;
  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cke = 1'b1;
  logic cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [1:0] ba = '0;
  logic [12:0] addr = '0;
  logic [1:0] dqm = '0;
  logic [15:0] dqi = '0;
  logic [15:0] dq_out;
  logic dq_oe, err;
  int cyc = 0;
  int t_cmd = 0;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  exp_t e;
  sdram_responder dut (
    .CLOCK_100 (clk),
    .rst       (rst),
    .DRAM_CKE  (cke),
    .DRAM_CS_N (cs_n),
    .DRAM_RAS_N(ras_n),
    .DRAM_CAS_N(cas_n),
    .DRAM_WE_N (we_n),
    .DRAM_BA   (ba),
    .DRAM_ADDR (addr),
    .DRAM_DQM  (dqm),
    .dq_in     (dqi),
    .dq_out    (dq_out),
    .dq_oe     (dq_oe),
    .err       (err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst && dq_oe) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read: dq_out=%h at cycle %0d, no word expected", dq_out, cyc);
      end else begin
        e = q.pop_front();
        if (dq_out !== e.d || cyc != e.c) begin
          failures++;
          $display("FAIL read_word: got %h at cycle %0d, expected %h at cycle %0d", dq_out, cyc, e.d, e.c);
        end
      end
    end
  end
  task automatic step(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a, input logic [1:0] m, input logic [15:0] d);
    @(negedge clk);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba = b;
    addr = a;
    dqm = m;
    dqi = d;
    t_cmd = cyc + 1;
  endtask
  task automatic nop(input int n);
    repeat (n) step(NOP, 2'd0, 13'd0, 2'b00, 16'h0);
  endtask
  task automatic expect_word(input int cl, input int k, input logic [15:0] d);
    q.push_back('{d, t_cmd + cl - 1 + k});
  endtask
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, got, want);
    end
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    {cs_n, ras_n, cas_n, we_n} = NOP;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    do_reset;
    chk("reset_dq_oe", dq_oe, 0);
    chk("reset_dq_out", dq_out, 0);
    chk("reset_err", err, 0);
    step(MRS, 0, 13'h022, 0, 0);
    step(ACT, 1, 13'd3, 0, 0);
    nop(1);
    step(WR, 1, 13'd4, 0, 16'hA000);
    for (int i = 1; i < 4; i++) step(NOP, 0, 0, 0, 16'hA000 + 16'(i));
    step(RD, 1, 13'd4, 0, 0);
    for (int k = 0; k < 4; k++) expect_word(2, k, 16'hA000 + 16'(k));
    nop(6);
    chk("bl4_err", err, 0);
    step(PRE, 1, 13'd0, 0, 0);
    step(MRS, 0, 13'h033, 0, 0);
    step(ACT, 1, 13'd3, 0, 0);
    nop(1);
    step(WR, 1, 13'd0, 0, 16'hB000);
    for (int i = 1; i < 8; i++) step(NOP, 0, 0, 0, 16'hB000 + 16'(i));
    step(RD, 1, 13'd6, 0, 0);
    for (int k = 0; k < 8; k++) expect_word(3, k, 16'hB000 + 16'((6 + k) % 8));
    nop(10);
    chk("bl8_wrap_err", err, 0);
    step(PRE, 1, 13'd0, 0, 0);
    step(MRS, 0, 13'h020, 0, 0);
    step(ACT, 1, 13'd3, 0, 0);
    nop(1);
    step(WR, 1, 13'd9, 2'b00, 16'hFFFF);
    step(WR, 1, 13'd9, 2'b10, 16'h1234);
    step(RD, 1, 13'd9, 0, 0);
    expect_word(2, 0, 16'hFF34);
    nop(1);
    step(WR, 1, 13'd9, 2'b01, 16'h56AB);
    step(RD, 1, 13'd9, 0, 0);
    expect_word(2, 0, 16'h5634);
    nop(1);
    step(RD, 1, 13'h409, 0, 0);
    expect_word(2, 0, 16'h5634);
    nop(2);
    step(ACT, 1, 13'd3, 0, 0);
    nop(2);
    chk("auto_precharge_err", err, 0);
    step(PRE, 0, 13'h400, 0, 0);
    step(MRS, 0, 13'h033, 0, 0);
    step(ACT, 1, 13'd3, 0, 0);
    nop(1);
    step(RD, 1, 13'd0, 0, 0);
    for (int k = 0; k < 3; k++) expect_word(3, k, 16'hB000 + 16'(k));
    nop(2);
    step(BST, 0, 13'd0, 0, 0);
    nop(6);
    step(RD, 1, 13'd0, 0, 0);
    nop(1);
    step(WR, 1, 13'h010, 0, 16'hC000);
    for (int i = 1; i < 8; i++) step(NOP, 0, 0, 0, 16'hC000 + 16'(i));
    step(RD, 1, 13'h010, 0, 0);
    for (int k = 0; k < 8; k++) expect_word(3, k, 16'hC000 + 16'(k));
    nop(12);
    chk("bst_flush_err", err, 0);
    do_reset;
    chk("reset2_err", err, 0);
    step(ACT, 2, 13'd0, 0, 0);
    step(RD, 2, 13'd0, 0, 0);
    nop(4);
    chk("trcd_err", err, 1);
    do_reset;
    step(ACT, 0, 13'd0, 0, 0);
    nop(2);
    chk("pre_ref_err", err, 0);
    step(REF, 0, 13'd0, 0, 0);
    nop(1);
    chk("ref_open_err", err, 1);
    do_reset;
    step(MRS, 0, 13'h042, 0, 0);
    nop(1);
    chk("mrs_bad_cl_err", err, 1);
    nop(2);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synthesizable responder for the 16-bit SDRAM command interface that the board-level design drives toward the external chip. It decodes DRAM_* commands, holds a small banked memory array, and returns read bursts with the programmed CAS latency. It checks protocol rules and latches an error flag. It sits in place of the physical SDRAM in simulation and in on-FPGA loopback builds, so the controller in `top` can be exercised against a known-good far end.

## Interface
Parameters:
- ROW_BITS, 4, implemented row address bits; upper DRAM_ADDR row bits are ignored.
- COL_BITS, 6, implemented column bits; upper column bits are ignored.
- TRCD, 2, minimum cycles from ACT to READ/WRITE on the same bank.
- TRP, 2, minimum cycles from PRE to ACT on the same bank.

Ports (one clock; reset is synchronous and active-high):
- CLOCK_100  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- DRAM_CKE  in  1  commands are ignored (treated as NOP) when 0.
- DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N  in  1 each  command strobes.
- DRAM_BA  in  2  bank select.
- DRAM_ADDR  in  13  row/column/mode address; A10 selects auto-precharge or all-bank precharge.
- DRAM_DQM  in  2  write byte mask; bit 1 masks [15:8], bit 0 masks [7:0].
- dq_in  in  16  write data from the bus.
- dq_out  out  16  read data.
- dq_oe  out  1  high exactly while read data is valid; the bench builds the tristate.
- err  out  1  sticky protocol-violation flag.

## Operation
- Command = {CS_N,RAS_N,CAS_N,WE_N}: 0111 NOP, 0011 ACT, 0101 READ, 0100 WRITE, 0110 BST, 0010 PRE, 0001 REF, 0000 MRS. CS_N=1 or CKE=0 means NOP.
- Per bank: open flag, open row, TRCD timer, TRP timer.
- ACT: opens the row. Raises err if the bank is already open or TRP has not elapsed.
- READ and WRITE:
  - Raise err if the bank is closed or TRCD has not elapsed; the command is then ignored.
  - A10=1 closes the bank after the final burst word and starts TRP.
- PRE: closes the bank in DRAM_BA, or all banks if A10=1. PRE to a closed bank is legal.
- REF: raises err if any bank is open; otherwise no effect.
- MRS: A[2:0] sets burst length (0→1, 1→2, 2→4, 3→8) and A[6:4] sets CAS latency (2 or 3).
  - Any other BL or CL encoding raises err and keeps the old value.
  - MRS with any bank open raises err.
- Bursts:
  - The address walks sequentially and wraps within the BL-aligned block (low log2(BL) column bits).
  - A new READ, WRITE or BST terminates the current burst.
  - WRITE during a read burst also discards read words still in the latency pipe; dq_oe drops the next cycle.
- DQM affects writes only. Read data is always driven.

## Timing
- Reset values:
  - dq_oe=0, dq_out=0, err=0.
  - All banks closed, all timers expired.
  - CL=2, BL=1, burst idle.
  - Memory contents are not reset.
- WRITE at edge T: word 0 is taken from dq_in at T. Word k is taken at T+k, with DQM sampled in the same cycle as its word.
- READ at edge T: word k appears on dq_out with dq_oe=1 in the cycle after edge T+CL-1+k, i.e. sampled by the initiator at edge T+CL+k.
- Write-then-read to the same address returns the new data when the READ is issued the cycle after the last write word.
- Timers:
  - Load TRCD-1 on ACT and TRP-1 on PRE or on auto-precharge completion.
  - Count down to 0 each cycle; a command is legal once its timer reads 0.
- rst mid-burst: returns to reset state on the next edge; dq_oe=0 the following cycle.

## Structure
- Package sdram_pkg holds:
  - the 4-bit command encodings above;
  - BL and CL encoding constants;
  - DRAM_ADDR and DRAM_BA widths, shared with the controller.
- Sub-module sdram_bank_state holds one bank's open flag, row register, TRCD and TRP timers. It is instantiated 4 times.
- Top level holds:
  - the command decoder;
  - the burst counter;
  - the CL delay line (depth 3, tapped by CL);
  - the memory array, 4·2^ROW_BITS·2^COL_BITS × 16, with byte write enables.

## Test plan
- Reset, then MRS A=0x022 (CL=2, BL=4); ACT bank 1 row 3; wait 2 cycles; WRITE col 4 with data 0xA000..0xA003; READ col 4. Required: 0xA000..0xA003 on dq_out in cycles T+2..T+5, dq_oe high for exactly 4 cycles, err=0.
- MRS CL=3 BL=8; READ col 6 on an open row. Required: wrapped order col 6,7,0,1,2,3,4,5 starting at T+3.
- WRITE 0x1234 with DQM=2'b10 over existing 0xFFFF. Required: readback 0xFF34.
- READ one cycle after ACT with TRCD=2. Required: err=1 and no data driven. Also: REF with bank 0 open. Required: err=1.
- READ BL=8 followed by BST at T+3. Required: only 3 words driven. Also: READ with A10=1, then ACT on the same bank TRP cycles after the burst ends. Required: err=0.
